// File: rtl/riscv_defs.sv
// Shared RV32I core definitions: memory geometry, instruction constants and
// the fetch-stage types used by ifetch and its legality checker.
package riscv_defs;

  localparam int unsigned NB_BYTE  = 8;
  localparam int unsigned NB_ADDR  = 32;
  localparam int unsigned NB_INSTR = 32;

  localparam logic [NB_ADDR-1:0]  MEM_SIZE  = 32'h0000_0400;
  localparam logic [NB_INSTR-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_RUN,
    FETCH_EXC,
    FETCH_HALT
  } fetch_state_t;

  typedef enum logic [1:0] {
    EXC_NONE,
    EXC_MISALIGN,
    EXC_RANGE
  } fetch_exc_t;

  typedef struct packed {
    logic                valid;
    logic [NB_INSTR-1:0] instr;
    logic [NB_ADDR-1:0]  pc;
    logic [NB_ADDR-1:0]  pc_plus4;
    logic                exc;
    fetch_exc_t          cause;
  } ifid_t;

endpackage

// File: rtl/imem_if.sv
// Instruction-memory port: the CPU presents a PC, the memory answers
// combinationally with the instruction word at that address.
interface imem_if
  import riscv_defs::*;
  ;
  logic [NB_ADDR-1:0]  imem_pc;
  logic [NB_INSTR-1:0] imem_instruction;

  modport cpu (output imem_pc, input imem_instruction);
  modport mem (input imem_pc, output imem_instruction);
endinterface

// File: rtl/fetch_pc_check.sv
// Combinational fetch-address legality check; misalignment outranks range.
module fetch_pc_check
  import riscv_defs::*;
(
  input  logic [NB_ADDR-1:0] pc,
  output fetch_exc_t         exc
);

  always_comb begin
    exc = EXC_NONE;
    if (pc[1:0] != 2'b00) begin
      exc = EXC_MISALIGN;
    end else if (pc > (MEM_SIZE - 32'd4)) begin
      exc = EXC_RANGE;
    end
  end

endmodule

// File: rtl/ifetch.sv
// RV32I instruction-fetch stage: PC register, IF/ID pipeline register with a
// valid/ready handshake, redirect handling, fetch exceptions and a beat counter.
module ifetch
  import riscv_defs::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  imem_if.cpu         IMEM_IF,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        if_exc,
  output logic [1:0]  if_exc_cause,
  output logic [31:0] fetch_count
);

  fetch_state_t       state_q, state_n;
  ifid_t              ifid_q, ifid_n;
  logic [NB_ADDR-1:0] pc_q, pc_n;
  logic [31:0]        count_q;
  fetch_exc_t         pc_exc;
  logic               advance;

  fetch_pc_check u_pc_check (
    .pc  (pc_q),
    .exc (pc_exc)
  );

  assign IMEM_IF.imem_pc = pc_q;
  assign advance         = !ifid_q.valid || id_ready;

  always_comb begin
    state_n = state_q;
    ifid_n  = ifid_q;
    pc_n    = pc_q;

    if (redirect_valid) begin
      // Wrong-path beat is dropped even while decode is stalled.
      pc_n         = redirect_pc;
      ifid_n.valid = 1'b0;
      ifid_n.exc   = 1'b0;
      ifid_n.cause = EXC_NONE;
      state_n      = FETCH_RUN;
    end else begin
      unique case (state_q)
        FETCH_RUN: begin
          if (advance) begin
            ifid_n.valid    = 1'b1;
            ifid_n.pc       = pc_q;
            ifid_n.pc_plus4 = pc_q + 32'd4;
            if (pc_exc == EXC_NONE) begin
              ifid_n.instr = IMEM_IF.imem_instruction;
              ifid_n.exc   = 1'b0;
              ifid_n.cause = EXC_NONE;
              pc_n         = pc_q + 32'd4;
            end else begin
              ifid_n.instr = NOP_INSTR;
              ifid_n.exc   = 1'b1;
              ifid_n.cause = pc_exc;
              state_n      = FETCH_EXC;
            end
          end
        end
        FETCH_EXC: begin
          if (id_ready) begin
            ifid_n.valid = 1'b0;
            ifid_n.exc   = 1'b0;
            ifid_n.cause = EXC_NONE;
            state_n      = FETCH_HALT;
          end
        end
        FETCH_HALT: begin
        end
        default: begin
          state_n = FETCH_HALT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= FETCH_RUN;
      pc_q            <= RESET_PC;
      ifid_q.valid    <= 1'b0;
      ifid_q.instr    <= NOP_INSTR;
      ifid_q.pc       <= '0;
      ifid_q.pc_plus4 <= 32'd4;
      ifid_q.exc      <= 1'b0;
      ifid_q.cause    <= EXC_NONE;
      count_q         <= '0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      ifid_q  <= ifid_n;
      if (ifid_q.valid && id_ready && !redirect_valid) begin
        count_q <= count_q + 32'd1;
      end
    end
  end

  assign if_valid     = ifid_q.valid;
  assign if_instr     = ifid_q.instr;
  assign if_pc        = ifid_q.pc;
  assign if_pc_plus4  = ifid_q.pc_plus4;
  assign if_exc       = ifid_q.exc;
  assign if_exc_cause = ifid_q.cause;
  assign fetch_count  = count_q;

endmodule
